// File: rtl/regfile_writeback_unit_pkg.sv
// Shared defaults and the queued writeback entry type for the register file
// writeback unit.
package regfile_writeback_unit_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry;

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Result-in / register-file-write-out bundle of the writeback unit; the unit
// itself is the slave side.
interface regfile_writeback_unit_if #(
    parameter int DATA_W = regfile_writeback_unit_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_writeback_unit_pkg::ADDR_W_DEF,
    parameter int CNT_W  = $clog2(regfile_writeback_unit_pkg::DEPTH_DEF) + 1
);

    logic              in0_valid;
    logic [ADDR_W-1:0] in0_addr;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic [ADDR_W-1:0] in1_addr;
    logic [DATA_W-1:0] in1_data;
    logic              in_ready;
    logic              drain_en;
    logic              flush;
    logic [DATA_W-1:0] data_write0;
    logic [ADDR_W-1:0] data_write0_address;
    logic              reg_write_enable0;
    logic [DATA_W-1:0] data_write1;
    logic [ADDR_W-1:0] data_write1_address;
    logic              reg_write_enable1;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport slave (
        input  in0_valid, in0_addr, in0_data,
        input  in1_valid, in1_addr, in1_data,
        input  drain_en, flush,
        output in_ready,
        output data_write0, data_write0_address, reg_write_enable0,
        output data_write1, data_write1_address, reg_write_enable1,
        output count, empty
    );

    modport master (
        output in0_valid, in0_addr, in0_data,
        output in1_valid, in1_addr, in1_data,
        output drain_en, flush,
        input  in_ready,
        input  data_write0, data_write0_address, reg_write_enable0,
        input  data_write1, data_write1_address, reg_write_enable1,
        input  count, empty
    );

endinterface

// File: rtl/regfile_writeback_unit_fifo.sv
// Dual-push, dual-pop circular entry store; exposes the two oldest entries and
// the occupancy count.
module wb_entry_fifo
    import regfile_writeback_unit_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ENTRY_W = ADDR_W_DEF + DATA_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push0_i,
    input  logic                     push1_i,
    input  logic [ENTRY_W-1:0]       wdata0_i,
    input  logic [ENTRY_W-1:0]       wdata1_i,
    input  logic [1:0]               popN_i,
    input  logic                     flush_i,
    output logic [ENTRY_W-1:0]       head0_o,
    output logic [ENTRY_W-1:0]       head1_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   headNext;
    logic [PTR_W-1:0]   slot1;
    logic [1:0]         pushN;
    logic               write0, write1;
    logic [ENTRY_W-1:0] slot0Data;

    // A lone in1 takes the first free slot so the queue never holds a hole.
    always_comb begin
        pushN     = {1'b0, push0_i} + {1'b0, push1_i};
        slot1     = tail_q + PTR_W'(1);
        headNext  = head_q + PTR_W'(1);
        slot0Data = push0_i ? wdata0_i : wdata1_i;
        write0    = !flush_i && (push0_i || push1_i);
        write1    = !flush_i && push0_i && push1_i;
        head_d    = head_q + PTR_W'(popN_i);
        tail_d    = tail_q + PTR_W'(pushN);
        count_d   = count_q + CNT_W'(pushN) - CNT_W'(popN_i);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (write0) mem_q[tail_q] <= slot0Data;
        if (write1) mem_q[slot1]  <= wdata1_i;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head0_o = mem_q[head_q];
    assign head1_o = mem_q[headNext];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback_unit.sv
// Writeback queue between two result producers and a two-port register file,
// with R0 suppression and same-address write merging.
module regfile_writeback_unit
    import regfile_writeback_unit_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    regfile_writeback_unit_if.slave  bus
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] head0, head1;
    logic [CNT_W-1:0]   count;
    logic               push0, push1, pop0, pop1;
    logic [1:0]         popN;
    logic [ADDR_W-1:0]  addr0, addr1;
    logic [DATA_W-1:0]  data0, data1;

    assign bus.in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
    assign push0        = bus.in_ready && bus.in0_valid;
    assign push1        = bus.in_ready && bus.in1_valid;

    // Pops only ever consume entries already present at the start of the cycle.
    assign pop0 = reset && bus.drain_en && (count != '0);
    assign pop1 = reset && bus.drain_en && (count >= CNT_W'(2));
    assign popN = {1'b0, pop0} + {1'b0, pop1};

    wb_entry_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push0_i  (push0),
        .push1_i  (push1),
        .wdata0_i ({bus.in0_addr, bus.in0_data}),
        .wdata1_i ({bus.in1_addr, bus.in1_data}),
        .popN_i   (popN),
        .flush_i  (bus.flush),
        .head0_o  (head0),
        .head1_o  (head1),
        .count_o  (count)
    );

    assign {addr0, data0} = head0;
    assign {addr1, data1} = head1;

    // R0 is hardwired zero, and the younger write wins when both hit one register.
    assign bus.data_write0         = pop0 ? data0 : '0;
    assign bus.data_write0_address = pop0 ? addr0 : '0;
    assign bus.reg_write_enable0   = pop0 && (addr0 != '0) && !(pop1 && (addr1 == addr0));
    assign bus.data_write1         = pop1 ? data1 : '0;
    assign bus.data_write1_address = pop1 ? addr1 : '0;
    assign bus.reg_write_enable1   = pop1 && (addr1 != '0);

    assign bus.count = count;
    assign bus.empty = (count == '0);

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit: directed vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_regfile_writeback_unit;
    import regfile_writeback_unit_pkg::*;

    localparam int DEPTH = DEPTH_DEF;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    wb_entry mq[$];

    regfile_writeback_unit_if bus ();

    regfile_writeback_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rstn;
        logic        v0;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic        drain;
        logic        flsh;
        logic        xen0;
        logic [2:0]  xa0;
        logic [15:0] xd0;
        logic        xen1;
        logic [2:0]  xa1;
        logic [15:0] xd1;
        int          xcount;
    } vec_t;

    vec_t table_q[13];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle at the falling edge, compare against the model just after, then advance the model.
    task automatic applyStimulus(input logic rstn, input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                                 input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                                 input logic drain, input logic flsh);
        int      sz;
        int      npop;
        bit      rdy;
        bit      x0, x1;
        wb_entry e;
        @(negedge clock);
        reset         = rstn;
        bus.in0_valid = v0;
        bus.in0_addr  = a0;
        bus.in0_data  = d0;
        bus.in1_valid = v1;
        bus.in1_addr  = a1;
        bus.in1_data  = d1;
        bus.drain_en  = drain;
        bus.flush     = flsh;
        #1;
        sz   = mq.size();
        rdy  = (DEPTH - sz) >= 2;
        npop = (rstn && drain) ? ((sz < 2) ? sz : 2) : 0;
        x1   = (npop == 2) && (mq[1].addr != 0);
        x0   = (npop >= 1) && (mq[0].addr != 0) && !((npop == 2) && (mq[1].addr == mq[0].addr));
        checkOutput("in_ready", 32'(bus.in_ready), 32'(rdy));
        checkOutput("count", 32'(bus.count), 32'(sz));
        checkOutput("empty", 32'(bus.empty), 32'(sz == 0));
        checkOutput("enable0", 32'(bus.reg_write_enable0), 32'(x0));
        checkOutput("enable1", 32'(bus.reg_write_enable1), 32'(x1));
        if (npop >= 1) begin
            checkOutput("addr0", 32'(bus.data_write0_address), 32'(mq[0].addr));
            checkOutput("data0", 32'(bus.data_write0), 32'(mq[0].data));
        end
        if (npop == 2) begin
            checkOutput("addr1", 32'(bus.data_write1_address), 32'(mq[1].addr));
            checkOutput("data1", 32'(bus.data_write1), 32'(mq[1].data));
        end
        if (sz == 0 || !rstn) begin
            checkOutput("idle_data0", 32'({bus.data_write0_address, bus.data_write0}), 32'(0));
            checkOutput("idle_data1", 32'({bus.data_write1_address, bus.data_write1}), 32'(0));
        end
        if (!rstn) begin
            mq.delete();
        end else begin
            repeat (npop) void'(mq.pop_front());
            if (flsh) begin
                mq.delete();
            end else if (rdy) begin
                if (v0) begin e.addr = a0; e.data = d0; mq.push_back(e); end
                if (v1) begin e.addr = a1; e.data = d1; mq.push_back(e); end
            end
        end
    endtask

    task automatic idle(input logic drain);
        applyStimulus(1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, drain, 1'b0);
    endtask

    task automatic pushPair(input logic [15:0] base, input logic drain);
        applyStimulus(1'b1, 1'b1, 3'(base), base, 1'b1, 3'(base + 16'd1), base + 16'd1, drain, 1'b0);
    endtask

    initial begin
        table_q[0]  = '{1'b0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        table_q[1]  = '{1'b1, 1, 3, 16'h1234, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        table_q[2]  = '{1'b1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 3, 16'h1234, 0, 0, 16'h0000, 1};
        table_q[3]  = '{1'b1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        table_q[4]  = '{1'b1, 1, 2, 16'hAAAA, 1, 2, 16'h5555, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        table_q[5]  = '{1'b1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 2, 16'hAAAA, 1, 2, 16'h5555, 2};
        table_q[6]  = '{1'b1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        table_q[7]  = '{1'b1, 1, 0, 16'hFFFF, 1, 5, 16'h0001, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        table_q[8]  = '{1'b1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'hFFFF, 1, 5, 16'h0001, 2};
        table_q[9]  = '{1'b1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        table_q[10] = '{1'b1, 0, 0, 16'h0000, 1, 4, 16'h00BE, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        table_q[11] = '{1'b1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 4, 16'h00BE, 0, 0, 16'h0000, 1};
        table_q[12] = '{1'b1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};

        reset = 1'b0;
        bus.in0_valid = 1'b0; bus.in0_addr = '0; bus.in0_data = '0;
        bus.in1_valid = 1'b0; bus.in1_addr = '0; bus.in1_data = '0;
        bus.drain_en  = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(table_q[i].rstn, table_q[i].v0, table_q[i].a0, table_q[i].d0,
                          table_q[i].v1, table_q[i].a1, table_q[i].d1, table_q[i].drain, table_q[i].flsh);
            checkOutput($sformatf("vec%0d_en0", i), 32'(bus.reg_write_enable0), 32'(table_q[i].xen0));
            checkOutput($sformatf("vec%0d_addr0", i), 32'(bus.data_write0_address), 32'(table_q[i].xa0));
            checkOutput($sformatf("vec%0d_data0", i), 32'(bus.data_write0), 32'(table_q[i].xd0));
            checkOutput($sformatf("vec%0d_en1", i), 32'(bus.reg_write_enable1), 32'(table_q[i].xen1));
            checkOutput($sformatf("vec%0d_addr1", i), 32'(bus.data_write1_address), 32'(table_q[i].xa1));
            checkOutput($sformatf("vec%0d_data1", i), 32'(bus.data_write1), 32'(table_q[i].xd1));
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'(table_q[i].xcount));
        end

        // Fill to 7, confirm backpressure, drain, then refill three times to wrap the pointers.
        for (int i = 0; i < 3; i++) pushPair(16'h1000 + 16'(2 * i), 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd7, 16'h1006, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        pushPair(16'h2000, 1'b0);
        checkOutput("full_ready", 32'(bus.in_ready), 32'(0));
        checkOutput("full_count", 32'(bus.count), 32'(7));
        idle(1'b0);
        checkOutput("full_hold_count", 32'(bus.count), 32'(7));
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b1);
        checkOutput("drained_count", 32'(bus.count), 32'(0));
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) pushPair(16'h3000 + 16'(16 * r + 2 * i), 1'b0);
            for (int i = 0; i < 3; i++) idle(1'b1);
        end
        idle(1'b1);
        checkOutput("wrap_count", 32'(bus.count), 32'(0));

        // Flush with a same-cycle push leaves the queue empty.
        pushPair(16'h4002, 1'b0);
        pushPair(16'h4004, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd3, 16'h4444, 1'b1, 3'd4, 16'h5555, 1'b0, 1'b1);
        idle(1'b1);
        checkOutput("flush_count", 32'(bus.count), 32'(0));
        checkOutput("flush_empty", 32'(bus.empty), 32'(1));
        checkOutput("flush_en0", 32'(bus.reg_write_enable0), 32'(0));
        checkOutput("flush_en1", 32'(bus.reg_write_enable1), 32'(0));

        // Reset mid-operation with five entries queued.
        pushPair(16'h5002, 1'b0);
        pushPair(16'h5004, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd6, 16'h5006, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("rst_count", 32'(bus.count), 32'(0));
        checkOutput("rst_en0", 32'(bus.reg_write_enable0), 32'(0));
        checkOutput("rst_en1", 32'(bus.reg_write_enable1), 32'(0));
        checkOutput("rst_ready", 32'(bus.in_ready), 32'(1));

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 63) != 0),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_unit.md
REGFILE_WRITEBACK_UNIT -- requirements
Module: regfile_writeback_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning queue entries (power of 2, at least 4).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning result data width.
REQ-003 The block SHALL have parameter ADDR_W, default 3, meaning register address width.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have ports in0_valid (input, 1), in0_addr (input, ADDR_W) and in0_data (input, DATA_W): the older result of the cycle.
REQ-007 The block SHALL have ports in1_valid (input, 1), in1_addr (input, ADDR_W) and in1_data (input, DATA_W): the younger result of the cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit: high when at least 2 entries are free.
REQ-009 The block SHALL have port drain_en, input, 1 bit: register file write permitted this cycle.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all queued results.
REQ-011 The block SHALL have ports data_write0 (output, DATA_W), data_write0_address (output, ADDR_W) and reg_write_enable0 (output, 1): register file write port 0.
REQ-012 The block SHALL have ports data_write1 (output, DATA_W), data_write1_address (output, ADDR_W) and reg_write_enable1 (output, 1): register file write port 1.
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1 bits: occupied entries.
REQ-014 The block SHALL have port empty, output, 1 bit: count == 0.

Function
REQ-015 The queue SHALL be an in-order circular buffer; in0 is older than in1 within a cycle.
REQ-016 Push SHALL occur only when in_ready is high; each valid input is pushed, in0 first.
REQ-017 If only in1_valid is high, in1 SHALL be pushed alone into the next free slot, with no hole left.
REQ-018 Valid inputs presented while in_ready is low SHALL be ignored; the sender holds them.
REQ-019 Pop SHALL occur only when drain_en is high and SHALL pop min(count, 2) entries present at the start of the cycle; entries pushed this cycle SHALL NOT pop this cycle.
REQ-020 Write port 0 SHALL carry the oldest popped entry and write port 1 the second oldest; outputs are combinational from the head entries.
REQ-021 Port 1 SHALL carry data from the second-oldest entry only; if only one entry pops, reg_write_enable1 SHALL be 0.
REQ-022 A popped entry with address 0 SHALL be consumed with its enable low, since R0 is hardwired zero.
REQ-023 If both popped entries target the same nonzero address, reg_write_enable0 SHALL be 0 and the younger value on port 1 wins.
REQ-024 While drain_en is low, or the queue is empty, both enables SHALL be 0.
REQ-025 Simultaneous push and pop SHALL update count by pushes minus pops in the same edge.
REQ-026 Pointers SHALL wrap modulo DEPTH; full/empty are distinguished by count.
REQ-027 Latency: a result pushed at edge N SHALL drive its write port, with enable high, in cycle N+1 when drain_en is high and it is at the head.
REQ-028 flush SHALL empty the queue at the next edge and take priority over same-cycle push; same-cycle pop outputs remain as computed before the flush.
REQ-029 in_ready SHALL equal (DEPTH - count) >= 2, derived from registered state only.

Reset
REQ-030 With reset low at a rising edge, the pointers and count SHALL become 0 and empty SHALL become 1.
REQ-031 During and after reset, both enables SHALL be 0 and in_ready SHALL be 1; write data and address outputs SHALL be 0.
REQ-032 A reset asserted mid-operation SHALL discard all entries, with no write enable in the cycle after the reset edge.

Structure
REQ-033 A shared package SHALL hold DATA_W, ADDR_W, DEPTH defaults and a wb_entry typedef containing addr and data.
REQ-034 One sub-module, wb_entry_fifo (dual-push, dual-pop circular storage with pointers and count), SHALL hold the storage; conflict and R0 masking logic SHALL stay in the top level.

Verification
REQ-035 Scenario: reset, then push (in0: R3 = 0x1234) with drain_en = 1 -> next cycle reg_write_enable0 = 1, address 3, data 0x1234, enable1 = 0, then empty = 1.
REQ-036 Scenario: push (R2 = 0xAAAA, R2 = 0x5555) in one cycle, drain -> enable0 = 0, enable1 = 1, address 2, data 0x5555.
REQ-037 Scenario: push (R0 = 0xFFFF, R5 = 0x0001), drain -> both entries consumed, enable0 = 0, port 1 writes R5 = 0x0001, count returns to 0.
REQ-038 Scenario: drain_en = 0, push pairs until count = 7 -> in_ready = 0; a further push is ignored and count stays 7; then drain_en = 1 -> 4 cycles of pops in order, with wrap-around verified after 3 further fills.
REQ-039 Scenario: count = 4, flush = 1 plus a valid push in the same cycle -> next cycle count = 0, empty = 1, no write enables.
REQ-040 Scenario: reset low while count = 5 -> next cycle count = 0, enables 0, in_ready = 1.
